// File: rtl/legv8_fetch_ctrl.sv
// LEGv8 fetch sequencer: owns the PC, issues instruction-memory requests
// over a req/gnt handshake and holds one fetched word in the IF/ID buffer.
module legv8_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSrc,
  input  logic [63:0]      Br_Tar,
  input  logic             halt,
  input  logic             id_stall,
  output logic             imem_req,
  output logic [63:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [63:0]      if_pc,
  output logic [31:0]      if_insn,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

  state_t             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [63:0]        if_pc_q, if_pc_d;
  logic [31:0]        insn_q, insn_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic redirect;
  logic xfer;
  logic consume;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A redirect seen during BOOT is dropped so boot always starts at RESET_PC.
  assign redirect  = PCSrc & (state_q != BOOT);
  // Request only when the buffer has room now or will be drained this edge.
  assign imem_req  = (state_q == FETCH) & ~PCSrc & ~halt & (~valid_q | ~id_stall);
  assign xfer      = imem_req & imem_gnt;
  assign consume   = valid_q & ~id_stall;

  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_pc     = if_pc_q;
  assign if_insn   = insn_q;
  assign fetch_cnt = cnt_q;

  // Next-state logic: FSM transitions, PC sequencing and buffer fill/drain.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if_pc_d = if_pc_q;
    insn_d  = insn_q;
    cnt_d   = cnt_q;

    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (!PCSrc && halt) state_d = HALT;
      HALT:    if (PCSrc) state_d = FETCH;
      default: state_d = BOOT;
    endcase

    if (redirect) begin
      // Flush wins over id_stall; the buffered word is on the wrong path.
      pc_d    = {Br_Tar[63:2], 2'b00};
      valid_d = 1'b0;
    end else if (xfer) begin
      // Refill may coincide with consumption of the previous word.
      insn_d  = imem_rdata;
      if_pc_d = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + 64'd4;
      cnt_d   = sat_inc(cnt_q);
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      if_pc_q <= 64'h0;
      insn_q  <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      if_pc_q <= if_pc_d;
      insn_q  <= insn_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_legv8_fetch_ctrl.sv
// Self-checking bench for legv8_fetch_ctrl: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
module tb_legv8_fetch_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             PCSrc;
  logic [63:0]      Br_Tar;
  logic             halt;
  logic             id_stall;
  logic             imem_req;
  logic [63:0]      imem_addr;
  logic             imem_gnt;
  logic [31:0]      imem_rdata;
  logic             if_valid;
  logic [63:0]      if_pc;
  logic [31:0]      if_insn;
  logic [CNT_W-1:0] fetch_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit          m_known = 0;
  bit          m_boot;
  bit          m_halt;
  logic [63:0] m_pc;
  bit          m_v;
  logic [63:0] m_ipc;
  logic [31:0] m_insn;
  int          m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hD503_201F;
  endfunction

  assign imem_rdata = rdata_of(imem_addr);

  legv8_fetch_ctrl #(.RESET_PC(64'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .Br_Tar(Br_Tar), .halt(halt),
    .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_insn(if_insn), .fetch_cnt(fetch_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model's view of whether a request should be up right now.
  function automatic bit m_req();
    return !m_boot && !m_halt && !PCSrc && !halt && (!m_v || !id_stall);
  endfunction

  task automatic check_all();
    if (!m_known) return;
    chk("imem_req",  {63'h0, imem_req}, {63'h0, m_req()});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid",  {63'h0, if_valid}, {63'h0, m_v});
    chk("if_pc",     if_pc, m_ipc);
    chk("if_insn",   {32'h0, if_insn}, {32'h0, m_insn});
    chk("fetch_cnt", {{(64-CNT_W){1'b0}}, fetch_cnt}, 64'(m_cnt));
  endtask

  task automatic model_update();
    bit r;
    if (rst) begin
      m_known = 1; m_boot = 1; m_halt = 0; m_pc = 64'h0;
      m_v = 0; m_ipc = 64'h0; m_insn = 32'h0; m_cnt = 0;
    end else if (!m_known) begin
      // nothing known before the first reset
    end else if (m_boot) begin
      m_boot = 0;
    end else if (PCSrc) begin
      m_pc   = Br_Tar & ~64'h3;
      m_v    = 0;
      m_halt = 0;
    end else begin
      r = m_req();
      if (r && imem_gnt) begin
        m_ipc  = m_pc;
        m_insn = rdata_of(m_pc);
        m_v    = 1;
        m_pc   = m_pc + 64'd4;
        if (m_cnt < CMAX) m_cnt++;
      end else if (m_v && !id_stall) begin
        m_v = 0;
      end
      if (halt) m_halt = 1;
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; PCSrc = 0; Br_Tar = 64'h0; halt = 0; id_stall = 0; imem_gnt = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
  endtask

  initial begin
    logic [63:0] saved;
    idle_inputs();
    rst = 1;

    // Reset then zero-wait streaming from address 0
    do_reset();
    chk("boot_req", {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_cnt", {{(64-CNT_W){1'b0}}, fetch_cnt}, 64'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stream_addr", imem_addr, 64'(i * 4));
      chk("stream_req", {63'h0, imem_req}, 64'h1);
      if (i > 0) chk("stream_ifpc", if_pc, 64'((i - 1) * 4));
      step();
    end
    chk("stream_cnt", {{(64-CNT_W){1'b0}}, fetch_cnt}, 64'd5);
    chk("stream_insn", {32'h0, if_insn}, {32'h0, rdata_of(64'h10)});

    // Decode stall with 0x8 buffered
    do_reset();
    step();
    step(); step(); step();
    chk("pre_stall_ifpc", if_pc, 64'h8);
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", {63'h0, imem_req}, 64'h0);
      chk("stall_ifpc", if_pc, 64'h8);
      chk("stall_insn", {32'h0, if_insn}, {32'h0, rdata_of(64'h8)});
      step();
    end
    id_stall = 0;
    #1;
    chk("unstall_req", {63'h0, imem_req}, 64'h1);
    step();
    chk("unstall_ifpc", if_pc, 64'hC);

    // Redirect while buffer valid and decode stalled
    id_stall = 1; PCSrc = 1; Br_Tar = 64'h103;
    step();
    PCSrc = 0; id_stall = 0;
    #1;
    chk("redir_valid", {63'h0, if_valid}, 64'h0);
    chk("redir_addr", imem_addr, 64'h100);
    step();
    chk("redir_ifpc", if_pc, 64'h100);

    // Wait states at 0x20
    PCSrc = 1; Br_Tar = 64'h20;
    step();
    PCSrc = 0; imem_gnt = 0;
    saved = 64'(fetch_cnt);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wait_addr", imem_addr, 64'h20);
      chk("wait_valid", {63'h0, if_valid}, 64'h0);
      chk("wait_cnt", 64'(fetch_cnt), saved);
      step();
    end
    imem_gnt = 1;
    step();
    chk("wait_done_ifpc", if_pc, 64'h20);
    chk("wait_done_cnt", 64'(fetch_cnt), saved + 64'd1);

    // Halt drains the buffer, then redirect resumes at 0x40
    halt = 1;
    #1;
    chk("halt_req", {63'h0, imem_req}, 64'h0);
    chk("halt_valid", {63'h0, if_valid}, 64'h1);
    step();
    chk("halt_drained", {63'h0, if_valid}, 64'h0);
    halt = 0;
    #1;
    chk("halted_req", {63'h0, imem_req}, 64'h0);
    step();
    halt = 1; PCSrc = 1; Br_Tar = 64'h40;
    step();
    halt = 0; PCSrc = 0;
    #1;
    chk("resume_addr", imem_addr, 64'h40);
    chk("resume_req", {63'h0, imem_req}, 64'h1);
    step();
    chk("resume_ifpc", if_pc, 64'h40);

    // PC wraparound
    PCSrc = 1; Br_Tar = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    PCSrc = 0;
    #1;
    chk("wrap_pre", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_addr", imem_addr, 64'h0);
    chk("wrap_ifpc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Reset mid-stream
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("mrst_valid", {63'h0, if_valid}, 64'h0);
    chk("mrst_cnt", {{(64-CNT_W){1'b0}}, fetch_cnt}, 64'h0);
    chk("mrst_addr", imem_addr, 64'h0);
    chk("mrst_req", {63'h0, imem_req}, 64'h0);
    step();
    chk("mrst_req2", {63'h0, imem_req}, 64'h1);

    // Counter saturation
    for (int i = 0; i < CMAX + 4; i++) step();
    chk("sat_cnt", {{(64-CNT_W){1'b0}}, fetch_cnt}, 64'(CMAX));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      PCSrc    = ($urandom_range(0, 9) == 0);
      Br_Tar   = {$urandom(), $urandom()};
      halt     = ($urandom_range(0, 7) == 0);
      id_stall = ($urandom_range(0, 2) == 0);
      imem_gnt = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
